// File: rtl/ub_readback_if.sv
// Bus bundle for the unified-buffer readback engine.
// Groups the host request, buffer read port and output stream.
interface ub_readback_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 7
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              busy;
    logic              err;

    modport slave (
        input  req_valid, req_addr, req_len,
        input  mem_rd_data, out_ready,
        output req_ready, mem_rd_en, mem_rd_addr,
        output out_valid, out_data, out_last,
        output busy, err
    );

    modport master (
        output req_valid, req_addr, req_len,
        output mem_rd_data, out_ready,
        input  req_ready, mem_rd_en, mem_rd_addr,
        input  out_valid, out_data, out_last,
        input  busy, err
    );
endinterface

// File: rtl/ub_readback.sv
// Unified-buffer readback: request in, credit-limited reads, stream out.
// Ports: clk, reset (sync, active-low), bus (ub_readback_if.slave).
module ub_readback #(
    parameter int DEPTH  = 64,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6,
    parameter int LEN_W  = 7
) (
    input  logic        clk,
    input  logic        reset,
    ub_readback_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LEN_W-1:0]  issue_cnt_q, issue_cnt_d;
    logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic              err_q, err_d;
    logic              inflight_q;

    logic [DATA_W-1:0] fifo_q [2];
    logic              wr_idx_q;
    logic              rd_idx_q;
    logic [1:0]        fifo_cnt_q;

    logic              req_ok;
    logic              head_vld;
    logic              pop;
    logic              push;
    logic [2:0]        used;
    logic              credit_ok;
    logic              issue;

    assign req_ok = (bus.req_len != '0) &&
                    (bus.req_len <= LEN_W'(DEPTH));

    assign head_vld = (fifo_cnt_q != 2'd0);
    assign pop      = head_vld & bus.out_ready;
    // Read data lands one cycle after its issue.
    assign push     = inflight_q;

    // FIFO slots plus the read in flight may never exceed two;
    // a pop this cycle frees a slot immediately.
    assign used      = {1'b0, fifo_cnt_q} + {2'b0, inflight_q};
    assign credit_ok = used < (3'd2 + {2'b0, pop});
    assign issue     = (state_q == READ) &&
                       (issue_cnt_q != '0) && credit_ok;

    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        issue_cnt_d = issue_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        err_d       = 1'b0;
        if (pop) begin
            beat_cnt_d = beat_cnt_q - LEN_W'(1);
        end
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (req_ok) begin
                        rd_ptr_d    = bus.req_addr;
                        issue_cnt_d = bus.req_len;
                        beat_cnt_d  = bus.req_len;
                        state_d     = READ;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            READ: begin
                if (issue) begin
                    rd_ptr_d    = rd_ptr_q + ADDR_W'(1);
                    issue_cnt_d = issue_cnt_q - LEN_W'(1);
                    if (issue_cnt_q == LEN_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && beat_cnt_q == LEN_W'(1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            rd_ptr_q    <= '0;
            issue_cnt_q <= '0;
            beat_cnt_q  <= '0;
            err_q       <= 1'b0;
            inflight_q  <= 1'b0;
            fifo_q[0]   <= '0;
            fifo_q[1]   <= '0;
            wr_idx_q    <= 1'b0;
            rd_idx_q    <= 1'b0;
            fifo_cnt_q  <= 2'd0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            issue_cnt_q <= issue_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            err_q       <= err_d;
            inflight_q  <= issue;
            if (push) begin
                fifo_q[wr_idx_q] <= bus.mem_rd_data;
                wr_idx_q         <= ~wr_idx_q;
            end
            if (pop) begin
                rd_idx_q <= ~rd_idx_q;
            end
            unique case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    // Outputs are forced to zero combinationally while reset is low,
    // so an abandoned transfer disappears in the reset cycle itself.
    assign bus.req_ready   = reset && (state_q == IDLE);
    assign bus.busy        = reset && (state_q != IDLE);
    assign bus.mem_rd_en   = reset && issue;
    assign bus.mem_rd_addr = reset ? rd_ptr_q : '0;
    assign bus.out_valid   = reset && head_vld;
    assign bus.out_data    = reset ? fifo_q[rd_idx_q] : '0;
    assign bus.out_last    = reset && head_vld &&
                             (beat_cnt_q == LEN_W'(1));
    assign bus.err         = reset && err_q;
endmodule
